// File: rtl/svc_rv_mmio_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : svc_rv_mmio_uart_pkg
// Purpose  : Register offsets, STATUS bit indices and serializer states for
//            the MMIO UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package svc_rv_mmio_uart_pkg;

    localparam logic [31:0] c_OFF_TXDATA = 32'h0;
    localparam logic [31:0] c_OFF_STATUS = 32'h4;
    localparam logic [31:0] c_OFF_CLKDIV = 32'h8;

    localparam int c_STAT_FULL    = 0;
    localparam int c_STAT_EMPTY   = 1;
    localparam int c_STAT_BUSY    = 2;
    localparam int c_STAT_OVF     = 3;
    localparam int c_STAT_CNT_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/svc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : svc_sync_fifo
// Purpose  : Single-clock FIFO; pushes while full are dropped, pops while
//            empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module svc_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_wdata,
    input  logic                       i_pop,
    output logic [DW-1:0]              o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_PW = $clog2(DEPTH);

    logic [DW-1:0]  r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_PW:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == (c_PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_PW+1)'(1);
                2'b01:   r_count <= r_count - (c_PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/svc_rv_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : svc_rv_mmio_uart_tx
// Purpose  : MMIO-mapped 8N1 UART transmitter with TX FIFO and programmable
//            bit period.
// Revision : 1.0 - initial release
// ============================================================================
module svc_rv_mmio_uart_tx
    import svc_rv_mmio_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CLKDIV_RST = 868,
    parameter int AW         = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_raddr,
    output logic [31:0] io_rdata,
    input  logic        io_wen,
    input  logic [31:0] io_waddr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wstrb,
    output logic        utx
);

    localparam int          c_CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] c_CLKDIV_RST = (CLKDIV_RST == 0) ? 16'd1 : 16'(CLKDIV_RST);

    logic [AW-1:0]  w_roff;
    logic [AW-1:0]  w_woff;
    logic           w_wr_tx;
    logic           w_wr_stat;
    logic           w_wr_div;
    logic           w_push;
    logic           w_pop;
    logic           w_ovf_set;
    logic           w_ovf_clr;
    logic [7:0]     w_fifo_rdata;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [c_CW-1:0] w_fifo_count;
    logic [31:0]    w_cnt32;
    logic [3:0]     w_cnt_sat;
    logic [15:0]    w_clkdiv_new;
    logic [31:0]    w_status;
    logic [31:0]    w_rdata_nxt;
    logic           w_busy;
    logic           w_bit_done;
    logic           w_unused;

    logic [15:0]    r_clkdiv;
    logic           r_ovf;
    logic [31:0]    r_rdata;

    tx_state_t      r_state;
    tx_state_t      w_state_nxt;
    logic [7:0]     r_shift;
    logic [7:0]     w_shift_nxt;
    logic [15:0]    r_period;
    logic [15:0]    w_period_nxt;
    logic [15:0]    r_tick;
    logic [15:0]    w_tick_nxt;
    logic [2:0]     r_bitidx;
    logic [2:0]     w_bitidx_nxt;
    logic           r_utx;
    logic           w_utx_nxt;

    assign w_unused = ^{io_raddr[31:AW], io_raddr[1:0], io_waddr[31:AW], io_waddr[1:0],
                        io_wdata[31:16], io_wstrb[3:2]};

    // Word-aligned offsets; upper address bits alias onto the same map.
    assign w_roff    = {io_raddr[AW-1:2], 2'b00};
    assign w_woff    = {io_waddr[AW-1:2], 2'b00};
    assign w_wr_tx   = io_wen && (w_woff == c_OFF_TXDATA[AW-1:0]);
    assign w_wr_stat = io_wen && (w_woff == c_OFF_STATUS[AW-1:0]);
    assign w_wr_div  = io_wen && (w_woff == c_OFF_CLKDIV[AW-1:0]);

    assign w_push    = w_wr_tx && io_wstrb[0];
    assign w_ovf_set = w_push && w_fifo_full;
    assign w_ovf_clr = w_wr_stat && io_wstrb[0] && io_wdata[c_STAT_OVF];

    svc_sync_fifo #(
        .DW    (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (io_wdata[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_clkdiv_new = {io_wstrb[1] ? io_wdata[15:8] : r_clkdiv[15:8],
                           io_wstrb[0] ? io_wdata[7:0]  : r_clkdiv[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clkdiv <= c_CLKDIV_RST;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_div) begin
                r_clkdiv <= (w_clkdiv_new == 16'd0) ? 16'd1 : w_clkdiv_new;
            end
            r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
        end
    end

    assign w_busy    = (r_state != ST_IDLE);
    assign w_cnt32   = 32'(w_fifo_count);
    assign w_cnt_sat = (w_cnt32 > 32'd15) ? 4'hF : w_cnt32[3:0];

    always_comb begin
        w_status                          = '0;
        w_status[c_STAT_FULL]             = w_fifo_full;
        w_status[c_STAT_EMPTY]            = w_fifo_empty;
        w_status[c_STAT_BUSY]             = w_busy;
        w_status[c_STAT_OVF]              = r_ovf;
        w_status[c_STAT_CNT_LSB +: 4]     = w_cnt_sat;
    end

    always_comb begin
        w_rdata_nxt = '0;
        if (w_roff == c_OFF_STATUS[AW-1:0]) begin
            w_rdata_nxt = w_status;
        end else if (w_roff == c_OFF_CLKDIV[AW-1:0]) begin
            w_rdata_nxt = {16'd0, r_clkdiv};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata_nxt;
        end
    end

    assign io_rdata = r_rdata;

    // r_tick counts the remaining cycles of the current bit, down to zero.
    assign w_bit_done = (r_tick == 16'd0);

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_period_nxt = r_period;
        w_tick_nxt   = r_tick;
        w_bitidx_nxt = r_bitidx;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_fifo_rdata;
                    w_period_nxt = r_clkdiv;
                    w_tick_nxt   = r_clkdiv - 16'd1;
                    w_state_nxt  = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_tick_nxt   = r_period - 16'd1;
                    w_bitidx_nxt = 3'd0;
                    w_state_nxt  = ST_DATA;
                end else begin
                    w_tick_nxt = r_tick - 16'd1;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_tick_nxt = r_period - 16'd1;
                    if (r_bitidx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_shift_nxt  = {1'b0, r_shift[7:1]};
                        w_bitidx_nxt = r_bitidx + 3'd1;
                    end
                end else begin
                    w_tick_nxt = r_tick - 16'd1;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tick_nxt = r_tick - 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Line level is registered from the next state so utx tracks r_state exactly.
    always_comb begin
        w_utx_nxt = 1'b1;
        case (w_state_nxt)
            ST_START: w_utx_nxt = 1'b0;
            ST_DATA:  w_utx_nxt = w_shift_nxt[0];
            default:  w_utx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_period <= 16'd1;
            r_tick   <= '0;
            r_bitidx <= '0;
            r_utx    <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_period <= w_period_nxt;
            r_tick   <= w_tick_nxt;
            r_bitidx <= w_bitidx_nxt;
            r_utx    <= w_utx_nxt;
        end
    end

    assign utx = r_utx;

endmodule
`default_nettype wire

// File: doc/svc_rv_mmio_uart_tx.md
SVC_RV_MMIO_UART_TX -- requirements
Module: svc_rv_mmio_uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning TX FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CLKDIV_RST, default 868, meaning reset bit period in clk cycles.
REQ-003 SHALL have parameter AW, default 10, meaning decoded MMIO byte-address bits; upper bits ignored.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 io_raddr  input  32  read byte address from the SoC.
REQ-007 io_rdata  output  32  read data, registered.
REQ-008 io_wen  input  1  write strobe, one cycle per write.
REQ-009 io_waddr  input  32  write byte address.
REQ-010 io_wdata  input  32  write data.
REQ-011 io_wstrb  input  4  byte-lane enables.
REQ-012 utx  output  1  serial line, idle high, 8N1, LSB first.

Function
REQ-013 Register map (offset = addr[AW-1:0], word aligned; addr[1:0] ignored): 0x0 TXDATA (W), 0x4 STATUS (R/W1C), 0x8 CLKDIV (R/W).
REQ-014 io_rdata SHALL reflect io_raddr sampled in cycle N, valid in cycle N+1, returned every cycle (no enable).
REQ-015 Reads of TXDATA and unmapped offsets SHALL return 0.
REQ-016 STATUS bits: [0] full, [1] empty, [2] busy (serializer not IDLE), [3] overflow (sticky), [7:4] FIFO count (saturating at 15), [31:8] 0.
REQ-017 Write to TXDATA with io_wstrb[0]=1 SHALL push io_wdata[7:0]; wstrb[0]=0 SHALL be ignored.
REQ-018 Push while full SHALL be dropped and set overflow, even if a pop occurs in the same cycle.
REQ-019 Write to STATUS with wstrb[0]=1 and wdata[3]=1 SHALL clear overflow; a same-cycle overflow set SHALL win over clear.
REQ-020 CLKDIV is 16 bits in [15:0]; each of wstrb[1:0] updates its byte; value 0 SHALL be stored as 1; [31:16] read 0.
REQ-021 Serializer states: IDLE -> START -> DATA -> STOP -> IDLE.
REQ-022 IDLE: utx=1; if FIFO non-empty, pop, latch byte and latch CLKDIV as bit period P, go START next cycle.
REQ-023 START: utx=0 for P cycles; DATA: 8 bits, bit0 first, P cycles each; STOP: utx=1 for P cycles.
REQ-024 Frame SHALL occupy exactly 10*P cycles from first low cycle; consecutive frames separated by exactly one IDLE cycle (11*P+1... i.e. start-to-start = 10*P+1).
REQ-025 CLKDIV writes mid-frame SHALL NOT affect the frame in progress.
REQ-026 utx SHALL be driven from a flop (glitch-free).
REQ-027 A read and a write in the same cycle SHALL both be served; read returns pre-write state.

Reset
REQ-028 On rst: FIFO empty, overflow=0, CLKDIV=CLKDIV_RST, state IDLE, utx=1, io_rdata=0.
REQ-029 rst mid-frame SHALL abort: utx=1 the cycle after rst is sampled, FIFO contents discarded.

Structure
REQ-030 Register offsets, STATUS bit indices and state enum SHALL live in package svc_rv_mmio_uart_pkg.
REQ-031 FIFO SHALL be one sub-module, svc_sync_fifo (DW=8, depth FIFO_DEPTH, full/empty/count outputs); serializer and register logic in this module.

Verification
REQ-032 Reset, read 0x4 -> rdata 0x0000_0002 next cycle; read 0x8 -> 868; utx=1.
REQ-033 CLKDIV=4, write 0x55 to 0x0 -> utx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, high 4; total 40 cycles; busy=1 throughout.
REQ-034 CLKDIV=2, write 9 bytes back-to-back with FIFO_DEPTH=8 before first pop -> 8 or 9 accepted per pop timing, excess dropped, overflow=1; W1C 0x8 to 0x4 clears it.
REQ-035 CLKDIV=3, two bytes queued -> second start bit begins exactly 31 cycles after first start bit.
REQ-036 Write CLKDIV=0 -> reads back 1; write CLKDIV=8 mid-frame -> current frame keeps old P, next frame uses 8.
REQ-037 Assert rst during DATA bit 3 -> utx=1 next cycle, STATUS reads 0x2, no residual frame emitted.
